instr_fetch_unit: RTL

- Fetch stage directly upstream of the main decoder.
- Holds the PC and fetches from instruction memory over a req/ack handshake with variable latency.
- Presents the fetched instruction (instr[31:26] is the decoder opcode) with a valid flag.
- Once the decoder/datapath release the instruction, computes the next PC from the branch, zero and jump signals.

---
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage in front of the main decoder. It holds the PC,
//               reads one instruction word over a req/ack handshake with
//               variable latency, and presents it with a valid flag. It
//               holds the word until the decoder/datapath release it, then
//               computes the next PC from the jump/branch/zero inputs.
//
// Ports:
//   clk, rst        - system clock (rising edge); synchronous active-high reset
//   imem_req        - memory read request (forced low while rst is high)
//   imem_addr       - byte address of the requested word (equals pc)
//   imem_ack        - response valid for the outstanding request
//   imem_rdata      - instruction word; sampled only on imem_req & imem_ack
//   stall           - downstream not ready; keeps the current instruction
//   branch, zero    - branch decision inputs for the held instruction
//   jump            - jump decision input for the held instruction
//   signimm         - sign-extended immediate of the held instruction
//   instr           - fetched instruction register
//   instr_valid     - instr holds a fetched, not yet retired instruction
//   pc, pc_plus4    - current instruction address and pc + 4
//   retire_count    - number of instructions released downstream (wraps)
//
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [31:0] signimm,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retire_count
);

    typedef enum logic [0:0] {
        ST_REQ  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic [31:0] r_retire_count;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;
    logic [31:0] w_next_pc;

    assign w_pc_plus4      = r_pc + 32'd4;
    // Jump target keeps the region bits of the sequential PC.
    assign w_jump_target   = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    assign w_branch_target = w_pc_plus4 + (signimm << 2);

    // The decoder also raises branch for j, so jump must be tested first.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jump) begin
            w_next_pc = w_jump_target;
        end else if (branch && zero) begin
            w_next_pc = w_branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_REQ;
            r_pc           <= RESET_PC;
            r_instr        <= 32'd0;
            r_instr_valid  <= 1'b0;
            r_retire_count <= 32'd0;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        r_pc           <= w_next_pc;
                        r_instr_valid  <= 1'b0;
                        r_retire_count <= r_retire_count + 32'd1;
                        r_state        <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_REQ;
                end
            endcase
        end
    end

    // Gating with rst lets the memory drop an outstanding request during reset.
    assign imem_req     = (r_state == ST_REQ) && !rst;
    assign imem_addr    = r_pc;
    assign instr        = r_instr;
    assign instr_valid  = r_instr_valid;
    assign pc           = r_pc;
    assign pc_plus4     = w_pc_plus4;
    assign retire_count = r_retire_count;

endmodule
`default_nettype wire
